// File: rtl/can_error_frame_tx_pkg.sv
// Shared constants for the CAN error-signalling blocks: bus levels, default field
// lengths and the error-frame transmitter state encoding.
package can_error_frame_tx_pkg;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  localparam int unsigned DEF_FLAG_LEN         = 6;
  localparam int unsigned DEF_DELIM_LEN        = 8;
  localparam int unsigned DEF_INTERMISSION_LEN = 3;
  localparam int unsigned DEF_MAX_DOM_WAIT     = 14;

  // Counter width: must hold the largest field length above.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLAG     = 3'd1,
    ST_WAIT_REC = 3'd2,
    ST_DELIM    = 3'd3,
    ST_INTERM   = 3'd4
  } err_state_e;

endpackage

// File: rtl/can_error_frame_tx.sv
// CAN error-frame transmitter: on any active-low error request sends flag, delimiter
// and intermission, one bit per SP edge, stretching the delimiter for superposed flags.
module can_error_frame_tx
  import can_error_frame_tx_pkg::*;
#(
  parameter int unsigned FLAG_LEN         = DEF_FLAG_LEN,
  parameter int unsigned DELIM_LEN        = DEF_DELIM_LEN,
  parameter int unsigned INTERMISSION_LEN = DEF_INTERMISSION_LEN,
  parameter int unsigned MAX_DOM_WAIT     = DEF_MAX_DOM_WAIT
) (
  input  logic       SP,
  input  logic       reset,
  input  logic       RX,
  input  logic       FORM_Error,
  input  logic       CRC_Error,
  input  logic       ACK_Error,
  input  logic       BIT_Error,
  input  logic       STUFF_Error,
  input  logic       error_passive,
  output logic       TX,
  output logic       ERR_Busy,
  output logic       ERR_Done,
  output logic       DOM_Overflow,
  output err_state_e o_dbg_state
);

  localparam logic [CNT_W-1:0] C_FLAG   = CNT_W'(FLAG_LEN);
  localparam logic [CNT_W-1:0] C_DELIM  = CNT_W'(DELIM_LEN);
  localparam logic [CNT_W-1:0] C_INTERM = CNT_W'(INTERMISSION_LEN);
  localparam logic [CNT_W-1:0] C_MAXDOM = CNT_W'(MAX_DOM_WAIT);

  err_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_passive;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf_n;

  err_state_e       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_err_req;
  logic             w_next_passive;
  logic             w_next_tx;
  logic             w_next_busy;
  logic             w_next_done;
  logic             w_next_ovf_n;

  assign w_err_req = ~&{FORM_Error, CRC_Error, ACK_Error, BIT_Error, STUFF_Error};
  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge SP) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_passive <= 1'b0;
      r_tx      <= RECESSIVE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf_n   <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_passive <= w_next_passive;
      r_tx      <= w_next_tx;
      r_busy    <= w_next_busy;
      r_done    <= w_next_done;
      r_ovf_n   <= w_next_ovf_n;
    end
  end

  // FLAG and INTERM count bits already driven; WAIT_REC and DELIM count bits seen on RX,
  // so their limits are judged on the value the current sample would bring cnt to.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_next_cnt = '0;
        if (w_err_req) begin
          w_next_state = ST_FLAG;
          w_next_cnt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_FLAG: begin
        if (r_cnt == C_FLAG) begin
          w_next_state = ST_WAIT_REC;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      ST_WAIT_REC: begin
        if (RX == RECESSIVE) begin
          w_next_state = ST_DELIM;
          w_next_cnt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (w_cnt_inc == C_MAXDOM) begin
          w_next_cnt = '0;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      ST_DELIM: begin
        if (RX == DOMINANT) begin
          w_next_state = ST_WAIT_REC;
          w_next_cnt   = '0;
        end else if (w_cnt_inc == C_DELIM) begin
          w_next_state = ST_INTERM;
          w_next_cnt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      ST_INTERM: begin
        if (r_cnt == C_INTERM) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_next_passive = r_passive;
    w_next_tx      = RECESSIVE;
    w_next_busy    = 1'b1;
    w_next_done    = 1'b0;
    w_next_ovf_n   = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_next_busy = 1'b0;
        if (w_err_req) begin
          w_next_passive = error_passive;
          w_next_tx      = error_passive ? RECESSIVE : DOMINANT;
          w_next_busy    = 1'b1;
        end
      end
      ST_FLAG: begin
        if (r_cnt != C_FLAG) begin
          w_next_tx = r_passive ? RECESSIVE : DOMINANT;
        end
      end
      ST_WAIT_REC: begin
        if ((RX == DOMINANT) && (w_cnt_inc == C_MAXDOM)) begin
          w_next_ovf_n = 1'b0;
        end
      end
      ST_DELIM: begin
        w_next_tx = RECESSIVE;
      end
      ST_INTERM: begin
        if (r_cnt == C_INTERM) begin
          w_next_done = 1'b1;
          w_next_busy = 1'b0;
        end
      end
      default: begin
        w_next_busy = 1'b0;
      end
    endcase
  end

  assign TX           = r_tx;
  assign ERR_Busy     = r_busy;
  assign ERR_Done     = r_done;
  assign DOM_Overflow = r_ovf_n;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_can_error_frame_tx.sv
// Directed bench for can_error_frame_tx: a vector table for the base active frame plus
// hand-written sequences for passive, superposed-flag, overflow, delimiter and reset cases.
module tb_can_error_frame_tx;
  import can_error_frame_tx_pkg::*;

  logic       SP;
  logic       reset;
  logic       RX;
  logic       FORM_Error, CRC_Error, ACK_Error, BIT_Error, STUFF_Error;
  logic       error_passive;
  logic       TX, ERR_Busy, ERR_Done, DOM_Overflow;
  err_state_e dbg_state;

  can_error_frame_tx dut (
    .SP            (SP),
    .reset         (reset),
    .RX            (RX),
    .FORM_Error    (FORM_Error),
    .CRC_Error     (CRC_Error),
    .ACK_Error     (ACK_Error),
    .BIT_Error     (BIT_Error),
    .STUFF_Error   (STUFF_Error),
    .error_passive (error_passive),
    .TX            (TX),
    .ERR_Busy      (ERR_Busy),
    .ERR_Done      (ERR_Done),
    .DOM_Overflow  (DOM_Overflow),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial SP = 1'b0;
  always #5 SP = ~SP;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // error bus order {FORM, CRC, ACK, BIT, STUFF}, active low
  localparam logic [4:0] E_NONE  = 5'b11111;
  localparam logic [4:0] E_FORM  = 5'b01111;
  localparam logic [4:0] E_CRC   = 5'b10111;
  localparam logic [4:0] E_ACKST = 5'b11010;

  typedef struct {
    logic       rx;
    logic [4:0] errs;
    logic       pas;
    logic       rst;
    logic [6:0] exp;  // {TX, ERR_Busy, ERR_Done, DOM_Overflow, state}
  } vec_t;

  vec_t vecs[$];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no, busy_cnt, tx0_cnt, done_cnt, done_edge;

  function automatic logic [6:0] pack(input logic tx, input logic busy, input logic done,
                                      input logic ovf, input err_state_e st);
    return {tx, busy, done, ovf, 3'(st)};
  endfunction

  function automatic logic [6:0] obs();
    return {TX, ERR_Busy, ERR_Done, DOM_Overflow, 3'(dbg_state)};
  endfunction

  function automatic void add_vec(input logic rx, input logic [4:0] errs, input logic pas,
                                  input logic [6:0] exp);
    vec_t v;
    v.rx = rx; v.errs = errs; v.pas = pas; v.rst = 1'b0; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // driver
  task automatic step(input logic rx, input logic [4:0] errs, input logic pas, input logic rst);
    RX = rx;
    {FORM_Error, CRC_Error, ACK_Error, BIT_Error, STUFF_Error} = errs;
    error_passive = pas;
    reset = rst;
    @(posedge SP);
    #1;
    edge_no++;
    if (ERR_Busy) busy_cnt++;
    if (!TX) tx0_cnt++;
    if (ERR_Done) begin
      done_cnt++;
      if (done_edge < 0) done_edge = edge_no;
    end
  endtask

  task automatic clear_mon();
    edge_no = 0; busy_cnt = 0; tx0_cnt = 0; done_cnt = 0; done_edge = -1;
  endtask

  task automatic do_reset();
    step(1'b1, E_NONE, 1'b0, 1'b1);
    clear_mon();
  endtask

  task automatic run_to_done(input int limit);
    int n;
    n = 0;
    while (done_edge < 0 && n < limit) begin
      step(1'b1, E_NONE, 1'b0, 1'b0);
      n++;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {tx,busy,done,ovf,st}=%b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    RX = 1'b1;
    {FORM_Error, CRC_Error, ACK_Error, BIT_Error, STUFF_Error} = E_NONE;
    error_passive = 1'b0;
    reset = 1'b1;
    clear_mon();

    // base active frame: error on edge 1, flag edges 1-6, delimiter 7-14, intermission 15-17
    add_vec(1'b1, E_FORM, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    add_vec(1'b1, E_NONE, 1'b1, pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    add_vec(1'b1, E_NONE, 1'b1, pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    add_vec(1'b1, E_FORM, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    add_vec(1'b1, E_NONE, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    add_vec(1'b1, E_NONE, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    add_vec(1'b1, E_NONE, 1'b0, pack(1'b1, 1'b1, 1'b0, 1'b1, ST_WAIT_REC));
    for (int i = 8; i <= 14; i++)
      add_vec(1'b1, E_NONE, 1'b0, pack(1'b1, 1'b1, 1'b0, 1'b1, ST_DELIM));
    for (int i = 15; i <= 17; i++)
      add_vec(1'b1, E_NONE, 1'b0, pack(1'b1, 1'b1, 1'b0, 1'b1, ST_INTERM));
    add_vec(1'b1, E_NONE, 1'b0, pack(1'b1, 1'b0, 1'b1, 1'b1, ST_IDLE));
    add_vec(1'b1, E_NONE, 1'b0, pack(1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE));

    do_reset();
    check("reset state", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rx, vecs[i].errs, vecs[i].pas, vecs[i].rst);
      check($sformatf("active edge %0d", i + 1), obs(), vecs[i].exp);
    end

    // passive flag: recessive throughout, error_passive dropped after frame start
    do_reset();
    step(1'b1, E_CRC, 1'b1, 1'b0);
    run_to_done(40);
    check_int("passive done edge", done_edge, 18);
    check_int("passive busy edges", busy_cnt, 17);
    check_int("passive dominant tx edges", tx0_cnt, 0);

    // superposed flag: 4 dominant bits after own flag delay the frame by 4
    do_reset();
    step(1'b1, E_FORM, 1'b0, 1'b0);
    for (int e = 2; e <= 11; e++) step(1'b0, E_NONE, 1'b0, 1'b0);
    check("superposed wait", obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, ST_WAIT_REC));
    step(1'b1, E_NONE, 1'b0, 1'b0);
    check("superposed delim", obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, ST_DELIM));
    run_to_done(40);
    check_int("superposed done edge", done_edge, 22);
    check_int("superposed flag width", tx0_cnt, 6);

    // overflow: 15 dominant bits after the flag, pulse only on the 14th
    do_reset();
    step(1'b1, E_FORM, 1'b0, 1'b0);
    for (int e = 2; e <= 7; e++) step(1'b1, E_NONE, 1'b0, 1'b0);
    for (int e = 8; e <= 22; e++) begin
      step(1'b0, E_NONE, 1'b0, 1'b0);
      check($sformatf("overflow edge %0d", e), obs(),
            pack(1'b1, 1'b1, 1'b0, (e == 21) ? 1'b0 : 1'b1, ST_WAIT_REC));
    end
    run_to_done(40);
    check_int("overflow done edge", done_edge, 33);

    // dominant on the 5th delimiter bit restarts a full delimiter
    do_reset();
    step(1'b1, E_FORM, 1'b0, 1'b0);
    for (int e = 2; e <= 11; e++) step(1'b1, E_NONE, 1'b0, 1'b0);
    check("delim before dominant", obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, ST_DELIM));
    step(1'b0, E_NONE, 1'b0, 1'b0);
    check("delim dominant", obs(), pack(1'b1, 1'b1, 1'b0, 1'b1, ST_WAIT_REC));
    run_to_done(40);
    check_int("delim restart done edge", done_edge, 23);

    // reset during the 3rd flag bit
    do_reset();
    step(1'b1, E_FORM, 1'b0, 1'b0);
    step(1'b1, E_NONE, 1'b0, 1'b0);
    step(1'b1, E_NONE, 1'b0, 1'b0);
    check("flag bit 3", obs(), pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));
    step(1'b1, E_NONE, 1'b0, 1'b1);
    check("mid-frame reset", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE));
    step(1'b1, E_NONE, 1'b0, 1'b0);
    step(1'b1, E_NONE, 1'b0, 1'b0);
    check("after reset idle", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE));
    check_int("mid-frame reset done pulses", done_cnt, 0);

    // simultaneous ACK+STUFF, held into the flag: one frame only
    do_reset();
    for (int e = 1; e <= 3; e++) step(1'b1, E_ACKST, 1'b0, 1'b0);
    run_to_done(40);
    for (int e = 0; e < 4; e++) step(1'b1, E_NONE, 1'b0, 1'b0);
    check_int("simultaneous done edge", done_edge, 18);
    check_int("simultaneous done pulses", done_cnt, 1);
    check_int("simultaneous busy edges", busy_cnt, 17);
    check("simultaneous final", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE));

    // request still pending right after ERR_Done starts a new frame on the next edge
    do_reset();
    for (int e = 1; e <= 18; e++) step(1'b1, E_FORM, 1'b0, 1'b0);
    check("back-to-back done", obs(), pack(1'b1, 1'b0, 1'b1, 1'b1, ST_IDLE));
    step(1'b1, E_FORM, 1'b0, 1'b0);
    check("back-to-back restart", obs(), pack(1'b0, 1'b1, 1'b0, 1'b1, ST_FLAG));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
